// File: rtl/johnson_pkg.sv
// Shared types and constants for Johnson-code consumers.
package johnson_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam int ERR_CNT_W   = 8;
  localparam int ERR_CNT_MAX = 255;

  // Index width for a WIDTH-bit Johnson code (2*WIDTH phases).
  function automatic int idx_width(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational Johnson-code legality check and binary phase decode.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IDX_W-1:0] index
);

  logic [WIDTH-2:0] diff;
  int               ones;
  int               transitions;
  int               idx_int;

  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_diff
      assign diff[gi] = code[gi] ^ code[gi+1];
    end
  endgenerate

  // A legal Johnson code is one run of ones and one run of zeros (at most one edge).
  always_comb begin
    ones        = $countones(code);
    transitions = $countones(diff);
    legal       = (transitions <= 1);
    if (code[WIDTH-1] || ones == 0) idx_int = ones;
    else                            idx_int = 2 * WIDTH - ones;
    index = idx_int[IDX_W-1:0];
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code monitor: decode, sequence tracking, lock detection and error counting.
// Define JOHNSON_DEC_ERRCNT_EN to build the saturating err_count register.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  localparam int IDX_W   = idx_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     code_in,
  input  logic                 code_valid,
  output logic [IDX_W-1:0]     index_out,
  output logic                 index_valid,
  output logic                 code_illegal,
  output logic                 seq_error,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] prev_reg, prev_next;
  logic [CNT_W-1:0] succ_reg, succ_next;

  logic             legal;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] expected;
  logic             is_succ;

  logic [IDX_W-1:0] index_next;
  logic             index_valid_next;
  logic             code_illegal_next;
  logic             seq_error_next;

  johnson_code_check #(.WIDTH(WIDTH)) u_check (
    .code  (code_in),
    .legal (legal),
    .index (idx)
  );

  assign expected = (prev_reg == IDX_W'(2 * WIDTH - 1)) ? '0 : prev_reg + 1'b1;
  assign is_succ  = legal && (idx == expected);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= UNLOCKED;
      prev_reg  <= '0;
      succ_reg  <= '0;
    end else begin
      state_reg <= state_next;
      prev_reg  <= prev_next;
      succ_reg  <= succ_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    prev_next  = prev_reg;
    succ_next  = succ_reg;
    if (code_valid) begin
      if (!legal) begin
        state_next = UNLOCKED;
        succ_next  = '0;
      end else begin
        prev_next = idx;
        unique case (state_reg)
          UNLOCKED: begin
            state_next = LOCKING;
            succ_next  = '0;
          end
          LOCKING: begin
            if (is_succ) begin
              succ_next = succ_reg + 1'b1;
              if (succ_reg == CNT_W'(LOCK_CNT - 1)) state_next = LOCKED;
            end else begin
              succ_next = '0;
            end
          end
          LOCKED: begin
            if (!is_succ) begin
              state_next = LOCKING;
              succ_next  = '0;
            end
          end
          default: begin
            state_next = UNLOCKED;
            succ_next  = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    index_valid_next  = code_valid && legal;
    code_illegal_next = code_valid && !legal;
    seq_error_next    = code_valid && (state_reg == LOCKED) && !is_succ;
    index_next        = (code_valid && legal) ? idx : index_out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_out    <= '0;
      index_valid  <= 1'b0;
      code_illegal <= 1'b0;
      seq_error    <= 1'b0;
    end else begin
      index_out    <= index_next;
      index_valid  <= index_valid_next;
      code_illegal <= code_illegal_next;
      seq_error    <= seq_error_next;
    end
  end

  assign locked = (state_reg == LOCKED);

`ifdef JOHNSON_DEC_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_reg;

  // An illegal sample while locked raises both flags but counts once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_reg <= '0;
    end else if ((code_illegal_next || seq_error_next) &&
                 (err_reg != ERR_CNT_W'(ERR_CNT_MAX))) begin
      err_reg <= err_reg + 1'b1;
    end
  end

  assign err_count = err_reg;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder with a sequence-table reference model.
module tb_johnson_decoder;

  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 3;
  localparam int NPH      = 2 * WIDTH;
`ifdef JOHNSON_DEC_ERRCNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] code_in = '0;
  logic             code_valid = 1'b0;
  logic [2:0]       index_out;
  logic             index_valid;
  logic             code_illegal;
  logic             seq_error;
  logic             locked;
  logic [7:0]       err_count;

  int n_checks = 0;
  int n_fail   = 0;

  johnson_decoder #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT)) dut (
    .clk          (clk),
    .reset        (reset),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .index_out    (index_out),
    .index_valid  (index_valid),
    .code_illegal (code_illegal),
    .seq_error    (seq_error),
    .locked       (locked),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Phase k of the Johnson sequence: k ones shifted in from the MSB, then drained.
  function automatic logic [WIDTH-1:0] phase_code(input int k);
    int v;
    if (k <= WIDTH) v = ((1 << k) - 1) << (WIDTH - k);
    else            v = (1 << (NPH - k)) - 1;
    return WIDTH'(v);
  endfunction

  function automatic bit lookup(input logic [WIDTH-1:0] c, output int idx);
    idx = 0;
    for (int k = 0; k < NPH; k++) begin
      if (phase_code(k) == c) begin
        idx = k;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Reference model: 0=unlocked, 1=locking, 2=locked.
  int m_state = 0, m_prev = 0, m_cnt = 0, m_err = 0;
  int e_idx = 0, e_iv = 0, e_ill = 0, e_seq = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_prev = 0; m_cnt = 0; m_err = 0;
      e_idx = 0; e_iv = 0; e_ill = 0; e_seq = 0;
    end else begin
      e_iv = 0; e_ill = 0; e_seq = 0;
      if (code_valid) begin
        int  idx;
        bit  lg, succ;
        lg   = lookup(code_in, idx);
        succ = lg && (idx == (m_prev + 1) % NPH);
        e_iv  = lg;
        e_ill = !lg;
        e_seq = (m_state == 2) && !succ;
        if ((e_ill || e_seq) && m_err < 255) m_err++;
        if (!lg) begin
          m_state = 0; m_cnt = 0;
        end else begin
          e_idx = idx;
          if (m_state == 0 || !succ) begin
            m_state = 1; m_cnt = 0;
          end else if (m_state == 1) begin
            m_cnt++;
            if (m_cnt == LOCK_CNT) m_state = 2;
          end
          m_prev = idx;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_index_out",    int'(index_out),    e_idx);
    chk("cyc_index_valid",  int'(index_valid),  e_iv);
    chk("cyc_code_illegal", int'(code_illegal), e_ill);
    chk("cyc_seq_error",    int'(seq_error),    e_seq);
    chk("cyc_locked",       int'(locked),       int'(m_state == 2));
    chk("cyc_err_count",    int'(err_count),    ERR_EN ? m_err : 0);
  end

  // Present one valid sample; returns #1 after the edge that registers it.
  task automatic send(input logic [WIDTH-1:0] c);
    code_in    = c;
    code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
    $display("sample code=%b -> index_out=%0d iv=%0d ill=%0d seq=%0d locked=%0d err=%0d",
             c, index_out, index_valid, code_illegal, seq_error, locked, err_count);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq_idx[6] = '{4, 5, 6, 7, 0, 1};
    logic [WIDTH-1:0] wrap_codes[6] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000};

    idle(3);
    chk("rst_index_out", int'(index_out), 0);
    chk("rst_locked",    int'(locked),    0);
    chk("rst_err",       int'(err_count), 0);
    reset = 1'b1;
    idle(10);
    chk("idle_index_valid", int'(index_valid), 0);
    chk("idle_locked",      int'(locked),      0);

    // Lock acquisition
    send(4'b0000); chk("lk0_idx", int'(index_out), 0); chk("lk0_iv", int'(index_valid), 1);
    send(4'b1000); chk("lk1_idx", int'(index_out), 1);
    send(4'b1100); chk("lk2_idx", int'(index_out), 2); chk("lk2_locked", int'(locked), 0);
    send(4'b1110); chk("lk3_idx", int'(index_out), 3); chk("lk3_locked", int'(locked), 1);

    // Wrap-around
    for (int i = 0; i < 6; i++) begin
      send(wrap_codes[i]);
      chk("wrap_idx", int'(index_out), exp_seq_idx[i]);
      chk("wrap_locked", int'(locked), 1);
      chk("wrap_seq", int'(seq_error), 0);
    end

    // Illegal code while locked
    send(4'b1010);
    chk("ill_code_illegal", int'(code_illegal), 1);
    chk("ill_seq_error",    int'(seq_error),    1);
    chk("ill_index_valid",  int'(index_valid),  0);
    chk("ill_index_hold",   int'(index_out),    1);
    chk("ill_locked",       int'(locked),       0);
    chk("ill_err",          int'(err_count),    ERR_EN);

    // Relock, then break the sequence at index 6
    send(4'b1100); send(4'b1110); send(4'b1111); send(4'b0111);
    chk("relock1_locked", int'(locked), 1);
    send(4'b0011); chk("brk_pre_idx", int'(index_out), 6);
    send(4'b1100);
    chk("brk_seq_error",    int'(seq_error),    1);
    chk("brk_code_illegal", int'(code_illegal), 0);
    chk("brk_idx",          int'(index_out),    2);
    chk("brk_locked",       int'(locked),       0);
    chk("brk_err",          int'(err_count),    2 * ERR_EN);
    send(4'b1110); send(4'b1111);
    chk("relock2_pre", int'(locked), 0);
    send(4'b0111);
    chk("relock2_locked", int'(locked), 1);

    // Idle cycles hold lock; a repeated code is not a successor
    idle(5);
    chk("gap_locked", int'(locked), 1);
    send(4'b0111);
    chk("rep_seq_error", int'(seq_error), 1);
    chk("rep_idx",       int'(index_out), 5);
    chk("rep_locked",    int'(locked),    0);

    // Saturation
    for (int i = 0; i < 300; i++) send(4'b0100);
    chk("sat_err",      int'(err_count),    ERR_EN ? 255 : 0);
    chk("sat_illegal",  int'(code_illegal), 1);
    chk("sat_seq",      int'(seq_error),    0);
    chk("sat_idx_hold", int'(index_out),    5);

    // Async reset mid-cycle while locked
    send(4'b0000); send(4'b1000); send(4'b1100); send(4'b1110);
    chk("pre_rst_locked", int'(locked), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_locked", int'(locked),    0);
    chk("arst_err",    int'(err_count), 0);
    chk("arst_idx",    int'(index_out), 0);
    chk("arst_iv",     int'(index_valid), 0);
    idle(2);
    reset = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the team's Johnson counter: samples a WIDTH-bit Johnson-coded word, checks that it is a legal code, and decodes it to a binary phase index 0..2·WIDTH-1. It tracks the expected sequence (successor = index+1 mod 2·WIDTH), acquires lock after LOCK_CNT consecutive correct successors, and flags illegal codes and sequence breaks. It sits downstream of any Johnson-counter source, such as a phase generator or a remote counter sampled across a link, as a monitor and binary converter.

## Interface
- WIDTH, 4: Johnson code width; sequence length is 2·WIDTH. Must be at least 2.
- LOCK_CNT, 3: number of consecutive correct successors after the first legal sample needed to assert lock. Must be at least 1.
- IDX_W, $clog2(2·WIDTH): width of the index output (derived, not overridable).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- code_in  in  WIDTH  Johnson-coded sample.
- code_valid  in  1  qualifies code_in for this cycle.
- index_out  out  IDX_W  decoded phase index.
- index_valid  out  1  one-cycle pulse: index_out was updated from a legal sample.
- code_illegal  out  1  one-cycle pulse: the sampled code was not a legal Johnson code.
- seq_error  out  1  one-cycle pulse: sequence break detected while locked.
- locked  out  1  level: decoder is locked to the sequence.
- err_count  out  8  saturating error counter.

## Operation
- **Legality:** code_in is legal iff the number of adjacent-bit transitions (code[i] != code[i+1], i=0..WIDTH-2) is ≤ 1. This yields exactly 2·WIDTH legal codes.
- **Decode:**
  - If code[WIDTH-1]==1 or code==0: index = popcount(code).
  - Otherwise: index = 2·WIDTH − popcount(code).
  - WIDTH=4 mapping: 0000→0, 1000→1, 1100→2, 1110→3, 1111→4, 0111→5, 0011→6, 0001→7.
- **Successor:** expected = (prev_index+1) mod 2·WIDTH. The wrap from 2·WIDTH−1 to 0 is legal. A repeated identical code is not a successor.
- **State machine** (states UNLOCKED, LOCKING, LOCKED); transitions occur only on code_valid=1:
  - UNLOCKED:
    - legal sample → LOCKING, succ_cnt=0, prev=index.
    - illegal sample → stay UNLOCKED.
  - LOCKING:
    - successor → succ_cnt+1; when succ_cnt reaches LOCK_CNT → LOCKED.
    - legal non-successor → stay LOCKING, succ_cnt=0, prev=index.
    - illegal sample → UNLOCKED.
  - LOCKED:
    - successor → stay LOCKED.
    - legal non-successor → seq_error, go to LOCKING with succ_cnt=0 and prev=new index.
    - illegal sample → seq_error and code_illegal, go to UNLOCKED.
- **Sampling rules:**
  - Cycles with code_valid=0 change nothing: no pulses, no timeout.
  - On an illegal sample, index_out holds its previous value and index_valid=0.
- **err_count:**
  - Increments by exactly 1 per sample with code_illegal or seq_error. A sample asserting both counts once.
  - Saturates at 255.
- **Reset:**
  - Asserting reset at any time, including mid-lock, immediately clears state to UNLOCKED and clears all outputs.
  - Reset values: index_out=0, index_valid=0, code_illegal=0, seq_error=0, locked=0, err_count=0, succ_cnt=0.

## Timing
- All outputs are registered. A code_valid sample at edge N produces index_valid, code_illegal and seq_error pulses in the cycle after edge N (latency 1).
- locked rises at the same edge that registers the LOCK_CNT-th successor, coincident with that sample's index_valid.
- locked falls at the edge that registers the breaking sample, coincident with seq_error.
- err_count updates at the same edge as the error pulse.
- Back-to-back valid samples every cycle are supported at full rate.

## Configuration
- JOHNSON_DEC_ERRCNT_EN defined: err_count register and saturation logic are built as specified.
- JOHNSON_DEC_ERRCNT_EN undefined: err_count is tied to 0 and the counter logic is absent. All other behaviour is unchanged.

## Structure
- Package johnson_pkg holds:
  - the state typedef (UNLOCKED, LOCKING, LOCKED);
  - the ERR_CNT_W=8 and ERR_CNT_MAX=255 constants;
  - a function computing the index width from WIDTH.
- Sub-module johnson_code_check, purely combinational: code_in → legal, index. It is reusable by other Johnson consumers.
- The top level holds the FSM, prev_index, succ_cnt, output registers and err_count.

## Test plan
All scenarios use WIDTH=4, LOCK_CNT=3.
- **Reset:** reset=0 → every output 0. Release, hold code_valid=0 for 10 cycles → outputs stay 0.
- **Lock acquisition:** valid 0000,1000,1100,1110 on consecutive cycles → index_out 0,1,2,3 with index_valid each cycle after sampling; locked=1 with index 3.
- **Wrap-around:** continue 1111,0111,0011,0001,0000,1000 → indices 4,5,6,7,0,1; locked stays 1; seq_error never asserts.
- **Illegal code while locked:** feed 1010 → code_illegal=1, seq_error=1, index_valid=0, index_out holds, err_count 0→1, locked=0.
- **Sequence break while locked:** at index 6 feed 1100 → seq_error=1, code_illegal=0, index_out=2, locked=0. Then 1110,1111,0111 → locked=1 again.
- **Saturation and async reset:** 300 illegal samples → err_count=255. Then assert reset while locked and mid-cycle → locked and err_count clear before the next clk edge.
